// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: instruction field
// positions, opcode/funct encodings, ALU operations, FSM states and decode.
package cpu_pkg;

  // Instruction field positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_MUL = 6'h18;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_MUL
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_e;

  // Opcode-level decode result; register-index legality is checked by the core
  typedef struct packed {
    logic    valid;
    logic    use_imm;
    logic    uses_rd;
    alu_op_e alu_op;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d.valid   = 1'b0;
    d.use_imm = 1'b0;
    d.uses_rd = 1'b0;
    d.alu_op  = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        d.valid   = 1'b1;
        d.uses_rd = 1'b1;
        case (funct)
          FN_ADD:  d.alu_op = ALU_ADD;
          FN_SUB:  d.alu_op = ALU_SUB;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_MUL:  d.alu_op = ALU_MUL;
          default: d.valid  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        d.valid   = 1'b1;
        d.use_imm = 1'b1;
      end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: add/sub/and/or/mul, all modulo 2^XLEN.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         alu_op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  // Select the operation; mul keeps only the low XLEN bits
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_MUL: result = a * b;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: IDLE/FETCH/DECODE/EXEC/WB sequencing with a
// req/ack instruction fetch, inline register file and a debug read port.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_data_i,
  output logic [PC_W-1:0] pc_o,
  output logic            retire_o,
  output logic            illegal_o,
  output logic [31:0]     retire_cnt_o,
  input  logic [4:0]      dbg_raddr_i,
  output logic [XLEN-1:0] dbg_rdata_o
);

  localparam int unsigned RW = $clog2(NREG);

  state_e            state;
  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic [XLEN-1:0]   regs [NREG];
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   imm;
  logic              use_imm;
  alu_op_e           alu_op_q;
  logic [4:0]        dst_q;
  logic              legal_q;
  logic [XLEN-1:0]   alu_out;
  logic              req;
  logic              retire;
  logic              illegal;
  logic [31:0]       retire_cnt;

  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [XLEN-1:0]   imm_ext;
  dec_t              dec;
  logic              dec_legal;
  logic [XLEN-1:0]   alu_b;
  logic [XLEN-1:0]   alu_res;
  logic              alu_zero;

  function automatic logic idx_ok(input logic [4:0] idx);
    return 32'(idx) < NREG;
  endfunction

  // Register 0 and out-of-range indices read as zero
  function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] idx);
    if (idx == '0 || !idx_ok(idx))
      return '0;
    return regs[idx[RW-1:0]];
  endfunction

  assign rs      = ir[RS_HI:RS_LO];
  assign rt      = ir[RT_HI:RT_LO];
  assign rd      = ir[RD_HI:RD_LO];
  assign imm_ext = XLEN'($signed(ir[IMM_HI:IMM_LO]));

  // Decode the latched instruction and check every register index it uses
  always_comb begin
    dec       = decode(ir[OP_HI:OP_LO], ir[FN_HI:FN_LO]);
    dec_legal = dec.valid && idx_ok(rs) && idx_ok(rt) && (!dec.uses_rd || idx_ok(rd));
  end

  assign alu_b = use_imm ? imm : op_b;

  cpu_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a      (op_a),
    .b      (alu_b),
    .alu_op (alu_op_q),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Instruction sequencer, datapath latches and register file
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      imm        <= '0;
      use_imm    <= 1'b0;
      alu_op_q   <= ALU_ADD;
      dst_q      <= '0;
      legal_q    <= 1'b0;
      alu_out    <= '0;
      req        <= 1'b0;
      retire     <= 1'b0;
      illegal    <= 1'b0;
      retire_cnt <= '0;
      for (int unsigned i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      retire  <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state <= S_FETCH;
            req   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack_i) begin
            ir    <= imem_data_i;
            req   <= 1'b0;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          op_a     <= rd_reg(rs);
          op_b     <= rd_reg(rt);
          imm      <= imm_ext;
          use_imm  <= dec.use_imm;
          alu_op_q <= dec.alu_op;
          dst_q    <= dec.uses_rd ? rd : rt;
          legal_q  <= dec_legal;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          state   <= S_WB;
        end
        S_WB: begin
          // legal_q guarantees dst_q < NREG, so the truncated index is exact
          if (legal_q && dst_q != '0)
            regs[dst_q[RW-1:0]] <= alu_out;
          pc      <= pc + PC_W'(4);
          retire  <= legal_q;
          illegal <= !legal_q;
          if (legal_q)
            retire_cnt <= retire_cnt + 32'd1;
          if (start_i) begin
            state <= S_FETCH;
            req   <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  // Debug port reads the register file combinationally
  always_comb begin
    dbg_rdata_o = rd_reg(dbg_raddr_i);
  end

  assign imem_req_o   = req;
  assign imem_addr_o  = pc;
  assign pc_o         = pc;
  assign retire_o     = retire;
  assign illegal_o    = illegal;
  assign retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: three instances (default, XLEN=16,
// NREG=8); expected retire/illegal events are queued by the stimulus and
// popped by per-instance monitors whenever the core pulses.
module tb_multicycle_cpu;

  typedef struct {
    bit          ill;
    logic [31:0] pc;
    logic [31:0] cnt;
    int          gap;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;

  // Instance 0: default parameters, controllable ack
  logic        start0, req0, ack0, ret0, ill0;
  logic [31:0] addr0, data0, pc0, cnt0, rdata0;
  logic [4:0]  dbg0;
  logic [31:0] prog0 [16];
  int          ack_delay;
  logic        ack_force;

  // Instance 1: XLEN=16, ack tied high
  logic        start1, req1, ret1, ill1;
  logic [31:0] addr1, data1, pc1, cnt1;
  logic [15:0] rdata1;
  logic [4:0]  dbg1;
  logic [31:0] prog1 [16];

  // Instance 2: NREG=8, ack tied high
  logic        start2, req2, ret2, ill2;
  logic [31:0] addr2, data2, pc2, cnt2, rdata2;
  logic [4:0]  dbg2;
  logic [31:0] prog2 [16];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   last0, last1, last2;

  assign data0 = prog0[addr0[5:2]];
  assign data1 = prog1[addr1[5:2]];
  assign data2 = prog2[addr2[5:2]];

  multicycle_cpu dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0),
    .imem_req_o(req0), .imem_addr_o(addr0), .imem_ack_i(ack0), .imem_data_i(data0),
    .pc_o(pc0), .retire_o(ret0), .illegal_o(ill0), .retire_cnt_o(cnt0),
    .dbg_raddr_i(dbg0), .dbg_rdata_o(rdata0)
  );

  multicycle_cpu #(.XLEN(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1),
    .imem_req_o(req1), .imem_addr_o(addr1), .imem_ack_i(1'b1), .imem_data_i(data1),
    .pc_o(pc1), .retire_o(ret1), .illegal_o(ill1), .retire_cnt_o(cnt1),
    .dbg_raddr_i(dbg1), .dbg_rdata_o(rdata1)
  );

  multicycle_cpu #(.NREG(8)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(1'b1), .imem_data_i(data2),
    .pc_o(pc2), .retire_o(ret2), .illegal_o(ill2), .retire_cnt_o(cnt2),
    .dbg_raddr_i(dbg2), .dbg_rdata_o(rdata2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push(input int which, input bit ill, input int pc, input int cnt, input int gap);
    exp_t e;
    e.ill = ill;
    e.pc  = pc;
    e.cnt = cnt;
    e.gap = gap;
    case (which)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsz(input int which);
    case (which)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic check_entry(input string tag, input exp_t e, input logic r, input logic il,
                             input logic [31:0] pc, input logic [31:0] cnt, input int gap);
    chk({tag, "_kind"}, {r, il}, e.ill ? 2'b01 : 2'b10);
    chk({tag, "_pc"}, pc, e.pc);
    chk({tag, "_cnt"}, cnt, e.cnt);
    if (e.gap != 0)
      chk({tag, "_gap"}, gap, e.gap);
  endtask

  // Scoreboard monitors: one per instance, triggered by retire/illegal pulses
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (ret0 || ill0)) begin
      chk("sb0_pending", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check_entry("sb0", e, ret0, ill0, pc0, cnt0, cyc - last0);
      end
      last0 = cyc;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (ret1 || ill1)) begin
      chk("sb1_pending", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check_entry("sb1", e, ret1, ill1, pc1, cnt1, cyc - last1);
      end
      last1 = cyc;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (ret2 || ill2)) begin
      chk("sb2_pending", q2.size() != 0, 1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check_entry("sb2", e, ret2, ill2, pc2, cnt2, cyc - last2);
      end
      last2 = cyc;
    end
  end

  // Fetch protocol watcher for instance 0: req held until ack, address stable
  logic        prev_req0, prev_ack0;
  logic [31:0] prev_addr0;
  always @(negedge clk) begin
    if (rst) begin
      prev_req0 = 1'b0;
      prev_ack0 = 1'b0;
    end else begin
      if (prev_req0 && !prev_ack0) begin
        chk("req_held", req0, 1'b1);
        chk("addr_stable", addr0, prev_addr0);
      end
      prev_req0  = req0;
      prev_ack0  = ack0;
      prev_addr0 = addr0;
    end
  end

  // Instruction memory for instance 0 with configurable wait states
  initial begin
    int wcnt;
    ack0 = 1'b0;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!req0) begin
        wcnt = 0;
        ack0 = ack_force;
      end else if (wcnt >= ack_delay) begin
        ack0 = 1'b1;
      end else begin
        ack0 = 1'b0;
        wcnt++;
      end
    end
  end

  task automatic wait_q(input int which, input int left, input int budget, input string name);
    int n;
    n = 0;
    while (qsz(which) > left && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_timeout"}, qsz(which) > left, 1'b0);
  endtask

  task automatic dchk(input int which, input logic [4:0] idx, input logic [63:0] exp, input string name);
    case (which)
      0:       dbg0 = idx;
      1:       dbg1 = idx;
      default: dbg2 = idx;
    endcase
    #1;
    case (which)
      0:       chk(name, rdata0, exp);
      1:       chk(name, rdata1, exp);
      default: chk(name, rdata2, exp);
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    dbg0 = '0; dbg1 = '0; dbg2 = '0;
    ack_delay = 0; ack_force = 1'b0;
    last0 = 0; last1 = 0; last2 = 0;
    for (int i = 0; i < 16; i++) begin
      prog0[i] = '0; prog1[i] = '0; prog2[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_req", req0, 1'b0);
    chk("rst_pc", pc0, 32'd0);
    chk("rst_cnt", cnt0, 32'd0);
    chk("rst_pulses", {ret0, ill0}, 2'b00);
    dchk(0, 5'd1, 64'd0, "rst_r1");

    // Test 1: ack tied high, addi/addi/add
    prog0[0] = 32'h20010005;  // addi r1,r0,5
    prog0[1] = 32'h2002FFFD;  // addi r2,r0,-3
    prog0[2] = 32'h00221820;  // add  r3,r1,r2
    push(0, 0, 4, 1, 0);
    push(0, 0, 8, 2, 4);
    push(0, 0, 12, 3, 4);
    @(posedge clk); #1 start0 = 1'b1;
    wait_q(0, 1, 60, "t1a");
    start0 = 1'b0;
    wait_q(0, 0, 60, "t1b");
    repeat (3) @(negedge clk);
    #1;
    chk("t1_pc", pc0, 32'd12);
    chk("t1_cnt", cnt0, 32'd3);
    chk("t1_req_idle", req0, 1'b0);
    dchk(0, 5'd1, 64'd5, "t1_r1");
    dchk(0, 5'd2, 64'hFFFFFFFD, "t1_r2");
    dchk(0, 5'd3, 64'd2, "t1_r3");

    // Test 2: same program, 3 wait states per fetch
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    chk("t2_rst_pc", pc0, 32'd0);
    ack_delay = 3;
    push(0, 0, 4, 1, 0);
    push(0, 0, 8, 2, 7);
    push(0, 0, 12, 3, 7);
    @(posedge clk); #1 start0 = 1'b1;
    wait_q(0, 1, 120, "t2a");
    start0 = 1'b0;
    wait_q(0, 0, 120, "t2b");
    repeat (3) @(negedge clk);
    #1;
    chk("t2_pc", pc0, 32'd12);
    chk("t2_cnt", cnt0, 32'd3);
    dchk(0, 5'd3, 64'd2, "t2_r3");

    // Test 5: drop start in DECODE, idle, then resume
    ack_delay = 0;
    prog0[3] = 32'h20040007;  // addi r4,r0,7
    prog0[4] = 32'h20850001;  // addi r5,r4,1
    push(0, 0, 16, 4, 0);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 start0 = 1'b0;
    chk("t5_req_after_ack", req0, 1'b0);
    chk("t5_pc_decode", pc0, 32'd12);
    wait_q(0, 0, 40, "t5a");
    repeat (6) @(negedge clk);
    #1;
    chk("t5_pc_idle", pc0, 32'd16);
    chk("t5_req_idle", req0, 1'b0);
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    ack_force = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_pc_spurious_ack", pc0, 32'd16);
    chk("t5_cnt", cnt0, 32'd4);
    dchk(0, 5'd4, 64'd7, "t5_r4");
    push(0, 0, 20, 5, 0);
    start0 = 1'b1;
    for (int i = 0; i < 10 && !req0; i++) @(negedge clk);
    chk("t5_refetch_req", req0, 1'b1);
    chk("t5_refetch_addr", addr0, 32'd16);
    start0 = 1'b0;
    wait_q(0, 0, 40, "t5b");
    repeat (2) @(negedge clk);
    #1;
    chk("t5_pc_final", pc0, 32'd20);
    dchk(0, 5'd5, 64'd8, "t5_r5");

    // Test 3: XLEN=16 wraparound and truncated multiply
    prog1[0] = 32'h20017FFF;  // addi r1,r0,0x7FFF
    prog1[1] = 32'h00211020;  // add  r2,r1,r1
    prog1[2] = 32'h00211818;  // mul  r3,r1,r1
    push(1, 0, 4, 1, 0);
    push(1, 0, 8, 2, 4);
    push(1, 0, 12, 3, 4);
    @(posedge clk); #1 start1 = 1'b1;
    wait_q(1, 1, 60, "t3a");
    start1 = 1'b0;
    wait_q(1, 0, 60, "t3b");
    repeat (3) @(negedge clk);
    #1;
    dchk(1, 5'd1, 64'h7FFF, "t3_r1");
    dchk(1, 5'd2, 64'hFFFE, "t3_r2");
    dchk(1, 5'd3, 64'h0001, "t3_r3");
    chk("t3_pc", pc1, 32'd12);

    // Test 4: illegal opcode, write to r0, out-of-range index with NREG=8
    prog2[0] = 32'hFC000000;  // op 0x3F
    prog2[1] = 32'h20000009;  // addi r0,r0,9
    prog2[2] = 32'h00214820;  // add  r9,r1,r1
    push(2, 1, 4, 0, 0);
    push(2, 0, 8, 1, 4);
    push(2, 1, 12, 1, 4);
    @(posedge clk); #1 start2 = 1'b1;
    wait_q(2, 1, 60, "t4a");
    start2 = 1'b0;
    wait_q(2, 0, 60, "t4b");
    repeat (3) @(negedge clk);
    #1;
    chk("t4_pc", pc2, 32'd12);
    chk("t4_cnt", cnt2, 32'd1);
    dchk(2, 5'd0, 64'd0, "t4_r0");
    dchk(2, 5'd9, 64'd0, "t4_dbg_oob");

    // Test 6: asynchronous reset in the middle of a stalled fetch
    ack_delay = 5;
    dbg0 = 5'd4;
    @(posedge clk); #1 start0 = 1'b1;
    for (int i = 0; i < 10 && !req0; i++) @(negedge clk);
    chk("t6_req_before", req0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_req_async", req0, 1'b0);
    chk("t6_pc", pc0, 32'd0);
    chk("t6_cnt", cnt0, 32'd0);
    chk("t6_r4", rdata0, 32'd0);
    chk("t6_cnt_dut1", cnt1, 32'd0);
    start0 = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    ack_force = 1'b1;
    repeat (4) @(negedge clk);
    ack_force = 1'b0;
    #1;
    chk("t6_pc_after", pc0, 32'd0);
    chk("t6_req_after", req0, 1'b0);
    chk("t6_cnt_after", cnt0, 32'd0);

    chk("queues_empty", q0.size() + q1.size() + q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
